// File: rtl/por_pkg.sv
// Shared definitions for the POR reset-release path: FSM encoding, voter and
// default parameter values.
package por_pkg;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_MISMATCH_LIMIT = 4;
  localparam int unsigned DEF_CNT_W          = 4;

  // Code 2'd3 is unused and is decoded as HOLD by the FSM.
  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } por_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/por_sync_bit.sv
// Synchroniser chain for one POR status bit; resets to 1 (POR assumed active).
module por_sync_bit
  import por_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '1;
    else     chain_q <= chain_d;
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/por_reset_release.sv
// Votes three synchronised POR bits, holds sys_rst_o until POR has been clear
// for HOLD_CYCLES, and monitors bit disagreement and POR re-assertions.
module por_reset_release
  import por_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned MISMATCH_LIMIT = DEF_MISMATCH_LIMIT,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       por_status,
  input  logic             err_clr,
  output logic             sys_rst_o,
  output logic             ready,
  output logic             por_voted,
  output logic             mismatch_err,
  output logic [CNT_W-1:0] por_count
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
  localparam int unsigned MIS_W  = $clog2(MISMATCH_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [MIS_W-1:0]  MIS_MAX   = MIS_W'(MISMATCH_LIMIT);

  logic [2:0] sync_bits;
  logic       disagree;

  for (genvar i = 0; i < 3; i++) begin : g_sync
    por_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (por_status[i]),
      .q   (sync_bits[i])
    );
  end

  assign por_voted = maj3(sync_bits);
  assign disagree  = (sync_bits != 3'b000) && (sync_bits != 3'b111);

  por_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              sys_rst_q, sys_rst_d;
  logic              ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (!por_voted) begin
          state_d    = ST_COUNT;
          hold_cnt_d = '0;
        end
      end
      ST_COUNT: begin
        if (por_voted)                    state_d    = ST_HOLD;
        else if (hold_cnt_q == HOLD_LAST) state_d    = ST_RUN;
        else                              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      ST_RUN: begin
        if (por_voted) state_d = ST_HOLD;
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Outputs decode the next state so they register on the same edge as it.
  always_comb begin
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  assign sys_rst_o = sys_rst_q;
  assign ready     = ready_q;

  logic [MIS_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             err_q, err_d;
  logic             mis_set;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_voted_q, prev_voted_d;
  logic             por_rise;

  always_comb begin
    mis_cnt_d = '0;
    if (disagree) mis_cnt_d = (mis_cnt_q == MIS_MAX) ? mis_cnt_q : mis_cnt_q + MIS_W'(1);
    mis_set = disagree && (mis_cnt_d == MIS_MAX);
    if (mis_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;

    por_rise     = por_voted && !prev_voted_q;
    prev_voted_d = por_voted;
    if (err_clr)                      cnt_d = CNT_W'(por_rise);
    else if (por_rise && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    else                              cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_cnt_q    <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      prev_voted_q <= 1'b1;
    end else begin
      mis_cnt_q    <= mis_cnt_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      prev_voted_q <= prev_voted_d;
    end
  end

  assign mismatch_err = err_q;
  assign por_count    = cnt_q;

endmodule

// File: tb/tb_por_reset_release.sv
// Bench for por_reset_release: directed scenarios with literal expectations and
// a randomised phase, all checked every cycle against a behavioural model.
module tb_por_reset_release;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned HOLD  = 16;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    por_status;
  logic          err_clr;
  logic          sys_rst_o;
  logic          ready;
  logic          por_voted;
  logic          mismatch_err;
  logic [CW-1:0] por_count;

  always #5 clk = ~clk;

  por_reset_release #(
    .SYNC_STAGES    (SYNC),
    .HOLD_CYCLES    (HOLD),
    .MISMATCH_LIMIT (LIMIT),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .por_status   (por_status),
    .err_clr      (err_clr),
    .sys_rst_o    (sys_rst_o),
    .ready        (ready),
    .por_voted    (por_voted),
    .mismatch_err (mismatch_err),
    .por_count    (por_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the synchronised view is simply the input seen SYNC edges ago;
  // release happens once the vote has been clear for HOLD+1 consecutive edges.
  logic [2:0] m_hist [SYNC];
  int         m_clear_run;
  int         m_mis_run;
  bit         m_err;
  bit         m_prev;
  int         m_cnt;
  bit         m_v, m_dis, m_rise;

  function automatic bit maj(input logic [2:0] v);
    return $countones(v) >= 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] = 3'b111;
      m_clear_run = 0;
      m_mis_run   = 0;
      m_err       = 1'b0;
      m_cnt       = 0;
      m_prev      = 1'b1;
    end else begin
      m_v   = maj(m_hist[SYNC-1]);
      m_dis = (m_hist[SYNC-1] != 3'b000) && (m_hist[SYNC-1] != 3'b111);
      if (m_v) m_clear_run = 0;
      else if (m_clear_run < HOLD + 1) m_clear_run++;
      if (m_dis) m_mis_run = (m_mis_run < LIMIT) ? m_mis_run + 1 : LIMIT;
      else       m_mis_run = 0;
      if (m_dis && m_mis_run == LIMIT) m_err = 1'b1;
      else if (err_clr)                m_err = 1'b0;
      m_rise = m_v && !m_prev;
      if (err_clr)                           m_cnt = m_rise ? 1 : 0;
      else if (m_rise && m_cnt < (1 << CW) - 1) m_cnt++;
      m_prev = m_v;
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = por_status;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sys_rst_o", sys_rst_o, (m_clear_run < HOLD + 1) ? 1 : 0);
      check("model_ready", ready, (m_clear_run >= HOLD + 1) ? 1 : 0);
      check("model_por_voted", por_voted, maj(m_hist[SYNC-1]) ? 1 : 0);
      check("model_mismatch_err", mismatch_err, m_err ? 1 : 0);
      check("model_por_count", por_count, m_cnt);
    end
  end

  // Counts edges (first edge after the call is 1) until the selected output
  // reaches the wanted value; returns limit+1 if it never does.
  task automatic edges_until(input int sel, input logic want, input int limit, output int n);
    logic val;
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      val = (sel == 0) ? sys_rst_o : mismatch_err;
      if (val === want) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int hold_len;
  int r;

  initial begin
    rst        = 1'b1;
    por_status = 3'b111;
    err_clr    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_sys_rst_o", sys_rst_o, 1);
    check("reset_ready", ready, 0);
    check("reset_por_voted", por_voted, 1);
    check("reset_mismatch_err", mismatch_err, 0);
    check("reset_por_count", por_count, 0);

    // Clean release
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    por_status = 3'b000;
    edges_until(0, 1'b0, 40, n);
    check("clean_release_edges", n, 19);
    check("clean_ready", ready, 1);
    check("clean_por_count", por_count, 0);
    check("clean_mismatch_err", mismatch_err, 0);

    // Glitch during COUNT restarts the hold
    @(negedge clk); por_status = 3'b111;
    repeat (4) @(negedge clk);
    por_status = 3'b000;
    repeat (10) @(negedge clk);
    por_status = 3'b111;
    @(negedge clk); por_status = 3'b000;
    edges_until(0, 1'b0, 40, n);
    check("glitch_release_edges", n, 19);

    // Single-bit fault in RUN
    @(negedge clk); por_status = 3'b010;
    edges_until(1, 1'b1, 20, n);
    check("mismatch_set_edges", n, 6);
    check("mismatch_sys_rst_o", sys_rst_o, 0);
    check("mismatch_por_voted", por_voted, 0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("mismatch_set_wins", mismatch_err, 1);
    por_status = 3'b000;
    repeat (8) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("mismatch_cleared", mismatch_err, 0);
    check("mismatch_count_cleared", por_count, 0);

    // POR re-assertion in RUN
    @(negedge clk); por_status = 3'b111;
    edges_until(0, 1'b1, 10, n);
    check("reassert_edges", n, 3);
    @(negedge clk); por_status = 3'b000;
    edges_until(0, 1'b0, 40, n);
    check("reassert_release_edges", n, 19);
    check("reassert_por_count", por_count, 1);

    // Counter saturation
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      por_status = 3'b111;
      repeat (3) @(negedge clk);
      por_status = 3'b000;
      repeat (3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("saturated_por_count", por_count, 15);
    por_status = 3'b111;
    @(negedge clk);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("clr_with_rise_count", por_count, 1);

    // Reset mid-COUNT
    por_status = 3'b000;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sys_rst_o", sys_rst_o, 1);
    check("midrst_ready", ready, 0);
    check("midrst_por_voted", por_voted, 1);
    check("midrst_mismatch_err", mismatch_err, 0);
    check("midrst_por_count", por_count, 0);
    @(negedge clk); rst = 1'b0;
    edges_until(0, 1'b0, 40, n);
    check("midrst_release_edges", n, 19);

    // Randomised phase, checked by the model every cycle
    hold_len = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (hold_len == 0) begin
        r = $urandom_range(0, 9);
        if (r < 5)      por_status = 3'b000;
        else if (r < 7) por_status = 3'b111;
        else if (r < 9) por_status = 3'(1 << $urandom_range(0, 2));
        else            por_status = 3'($urandom_range(0, 7));
        hold_len = (por_status == 3'b000) ? $urandom_range(1, 40) : $urandom_range(1, 8);
      end else begin
        hold_len--;
      end
      err_clr = ($urandom_range(0, 31) == 0);
      rst     = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst     = 1'b0;
    err_clr = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/por_reset_release.md
Name: por_reset_release

Overview:
- Consumer end of the power-on-reset status path.
- Takes the three redundant POR status bits and the combined system reset, and synchronises each bit to clk.
- Majority-votes the bits and holds a clean, registered system reset until POR has been stably deasserted for a programmable hold time.
- Flags persistent disagreement between the redundant bits and counts POR re-assertions for monitoring. Sits between the reset generator and all downstream synchronous logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per POR status bit (>=2).
- HOLD_CYCLES, 16, consecutive voted-clear cycles required before reset release (>=2).
- MISMATCH_LIMIT, 4, consecutive cycles of bit disagreement before mismatch_err sets (>=1).
- CNT_W, 4, width of the POR event counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset; one clock, reset is synchronous and active-high.
- por_status  input  3  redundant POR bits (A=bit0, B=bit1, C=bit2), asynchronous to clk, 1 = POR active.
- err_clr  input  1  single-cycle clear of mismatch_err and por_count.
- sys_rst_o  output  1  registered active-high reset for downstream logic.
- ready  output  1  high when the FSM is in RUN.
- por_voted  output  1  majority of the synchronised POR bits.
- mismatch_err  output  1  sticky flag: the redundant bits disagreed for MISMATCH_LIMIT consecutive cycles.
- por_count  output  CNT_W  saturating count of voted POR rising edges.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All sync flops load 1 (pessimistic: POR active), so por_voted=1.
  - State HOLD; sys_rst_o=1, ready=0, mismatch_err=0, por_count=0.
  - Hold and mismatch counters load 0.
  - rst asserted mid-operation returns everything to these values at the next edge.
- Synchronisation: each por_status bit passes through its own SYNC_STAGES flop chain. por_voted = maj3 of the chain outputs and is combinational from the sync flops.
- FSM:
  - HOLD: sys_rst_o=1. If por_voted=0, go to COUNT with hold_cnt=0.
  - COUNT: sys_rst_o=1.
    - If por_voted=1, go to HOLD.
    - Else if hold_cnt==HOLD_CYCLES-1, go to RUN.
    - Else hold_cnt++.
  - RUN: sys_rst_o=0, ready=1. If por_voted=1, go to HOLD.
- Output timing:
  - sys_rst_o and ready are registered together with the state.
  - sys_rst_o falls exactly SYNC_STAGES+HOLD_CYCLES+1 edges after the first edge that samples por_status=000 with rst=0 (19 with defaults).
  - A voted POR glitch during COUNT restarts the full hold.
  - Re-assertion in RUN raises sys_rst_o SYNC_STAGES+1 edges after the input edge.
- Mismatch detection:
  - When the synchronised bits are not all equal, mis_cnt increments, saturating at MISMATCH_LIMIT.
  - When they agree, mis_cnt loads 0.
  - mismatch_err sets on the edge where mis_cnt reaches MISMATCH_LIMIT and stays set until err_clr.
  - If err_clr and the set condition occur together, set wins.
  - A single disagreeing bit never changes por_voted or the FSM.
- por_count:
  - Increments on each 0->1 transition of por_voted (registered previous value, reset to 1, so the initial reset does not count).
  - Saturates at all ones.
  - err_clr loads 0; err_clr coincident with an increment loads 1.

Decomposition:
- Package por_pkg holds:
  - the state encoding (HOLD=2'd0, COUNT=2'd1, RUN=2'd2; the unused code decodes to HOLD);
  - the maj3 function;
  - the default parameter constants.
- Sub-module por_sync_bit: a SYNC_STAGES-deep flop chain with synchronous reset to 1, instantiated three times.
- Everything else stays in the top module.

Test Plan:
- Clean release: rst high 5 cycles, then low with por_status=111; switch to 000 at cycle 10 -> sys_rst_o falls and ready rises at cycle 29; por_count=0; mismatch_err=0.
- Glitch in hold: after release starts, por_status=111 for 1 cycle at hold_cnt=8 -> FSM back to HOLD; release occurs a full 19 cycles after the bits return to 000.
- Single-bit fault: in RUN, drive por_status=010 indefinitely -> sys_rst_o stays 0; mismatch_err sets 4 cycles after the synchronised disagreement and stays set; err_clr for 1 cycle while the fault persists -> mismatch_err stays 1 (set wins). Drive 000 for more than MISMATCH_LIMIT cycles, then pulse err_clr -> mismatch_err clears and stays 0.
- POR re-assertion: in RUN, drive 111 for 3 cycles and then 000 -> sys_rst_o=1 three edges after the input change; por_count=1; release 19 cycles after the return to 000.
- Counter saturation: 20 POR pulses (CNT_W=4) -> por_count=15. err_clr coincident with a rising vote -> por_count=1.
- Reset mid-COUNT: assert rst at hold_cnt=10 -> next edge state HOLD, sys_rst_o=1, all flags 0. With por_status=000, after rst deasserts the release takes the full 19 cycles.
